// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared types and defaults for the TX sample path
package tx_pkg;

    // Read-side scheduler states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } tx_state_t;

    // Midscale sample driven whenever no real sample is available
    localparam logic [7:0] TX_IDLE_SAMPLE = 8'h80;

    // Default FIFO occupancy width and sample-period divider width
    localparam int TX_LEVEL_W = 12;
    localparam int TX_RATE_W  = 16;

    // Default occupancy required before RUN starts or resumes
    localparam int TX_PREFILL = 64;

endpackage

// File: rtl/tx_rate_tick.sv
// rtl/tx_rate_tick.sv - loadable down-counter producing a one-cycle period tick
module tx_rate_tick
    import tx_pkg::*;
#(
    parameter int RATE_W = TX_RATE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              run,
    input  logic [RATE_W-1:0] period,
    output logic              tick
);

    logic [RATE_W-1:0] count;

    // A zero count while running is a tick, so a freshly cleared counter ticks at once
    assign tick = run && (count == '0);

    // Reload with the period sampled on the tick; a new period only applies after the current one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            if (tick) begin
                count <= period;
            end else begin
                count <= count - RATE_W'(1);
            end
        end
    end

endmodule

// File: rtl/tx_sample_scheduler.sv
// rtl/tx_sample_scheduler.sv - paces TX FIFO reads into registered modulator samples
module tx_sample_scheduler
    import tx_pkg::*;
#(
    parameter int         LEVEL_W     = TX_LEVEL_W,
    parameter int         RATE_W      = TX_RATE_W,
    parameter int         PREFILL     = TX_PREFILL,
    parameter logic [7:0] IDLE_SAMPLE = TX_IDLE_SAMPLE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [RATE_W-1:0]  rate_div,
    input  logic [LEVEL_W-1:0] fifo_level,
    input  logic               fifo_empty,
    input  logic [7:0]         fifo_q,
    output logic               fifo_rd,
    output logic [7:0]         sample_out,
    output logic               sample_stb,
    input  logic               underrun_clr,
    output logic               underrun,
    output logic [7:0]         underrun_cnt,
    output logic               busy
);

    localparam logic [LEVEL_W-1:0] PREFILL_LEVEL = LEVEL_W'(PREFILL);

    tx_state_t state;
    logic      tick;
    logic      tick_run;
    logic      tick_clr;
    logic      underrun_evt;

    // Ticks only count in RUN with enable still high; any other condition discards the partial period
    assign tick_run = (state == ST_RUN) && enable;
    assign tick_clr = !tick_run;

    tx_rate_tick #(
        .RATE_W (RATE_W)
    ) u_rate_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (tick_clr),
        .run    (tick_run),
        .period (rate_div),
        .tick   (tick)
    );

    // Pop is combinational so the FIFO head is consumed in the same cycle it is captured
    assign fifo_rd      = tick && !fifo_empty;
    assign underrun_evt = tick && fifo_empty;
    assign busy         = (state != ST_IDLE);

    // Scheduler FSM with registered sample and strobe; enable low overrides every transition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            sample_out <= IDLE_SAMPLE;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            if (!enable) begin
                state      <= ST_IDLE;
                sample_out <= IDLE_SAMPLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_PREFILL;
                    end
                    ST_PREFILL: begin
                        if (fifo_level >= PREFILL_LEVEL) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            sample_stb <= 1'b1;
                            if (fifo_empty) begin
                                sample_out <= IDLE_SAMPLE;
                                state      <= ST_PREFILL;
                            end else begin
                                sample_out <= fifo_q;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky underrun flag (a new event beats a clear) and saturating event count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun     <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            if (underrun_evt) begin
                underrun <= 1'b1;
                if (underrun_cnt != 8'hFF) begin
                    underrun_cnt <= underrun_cnt + 8'd1;
                end
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/tx_sample_scheduler.md
# tx_sample_scheduler

Read-side scheduler for the TX sample FIFO. Once the controller enables transmission, it waits for a prefill threshold, then pops one byte every `rate_div+1` clocks and presents it to the modulator as a registered sample with a strobe. On underrun it substitutes a midscale idle sample, records the event, and returns to prefill. It sits between the FIFO read port and the modulator/DAC path, beside the SPI controller that fills the FIFO and programs the frequency registers.

## Interface
Parameters:
- `LEVEL_W`, 12: width of the FIFO occupancy count.
- `RATE_W`, 16: width of the sample-period divider.
- `PREFILL`, 64: occupancy needed before RUN starts or resumes.
- `IDLE_SAMPLE`, 8'h80: value driven when no sample is available.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; transmission requested (from controller).
- `rate_div`  in  RATE_W  sample period minus one, in clocks.
- `fifo_level`  in  LEVEL_W  current FIFO occupancy.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_q`  in  8  show-ahead FIFO head data, valid while `!fifo_empty`.
- `fifo_rd`  out  1  pop strobe; one cycle per sample.
- `sample_out`  out  8  registered sample to the modulator.
- `sample_stb`  out  1  one-cycle pulse, `sample_out` updated this cycle.
- `underrun_clr`  in  1  clears `underrun`.
- `underrun`  out  1  sticky underrun flag.
- `underrun_cnt`  out  8  saturating underrun count; cleared only by reset.
- `busy`  out  1  high in PREFILL or RUN.

## Operation
- **States:**
  - IDLE: exits to PREFILL when `enable` is high.
  - PREFILL: exits to RUN when `fifo_level >= PREFILL`.
  - RUN: on an underrun, goes to PREFILL.
  - Any state: goes to IDLE when `enable` is low; this has priority over all other transitions.
- **Tick counter:**
  - Loaded with 0 on entry to RUN, so a tick occurs in the first RUN cycle.
  - On each tick, it reloads with `rate_div` sampled at that cycle. A `rate_div` change takes effect after the current period.
- **Tick with `!fifo_empty`:**
  - `fifo_rd`=1 combinationally in the same cycle.
  - `sample_out`<=`fifo_q`, and `sample_stb`<=1, both registered.
- **Tick with `fifo_empty`:**
  - No pop.
  - `sample_out`<=IDLE_SAMPLE and `sample_stb`<=1.
  - `underrun`<=1, `underrun_cnt`+=1 (saturates at 255).
  - State goes to PREFILL.
- **`rate_div`=0:** one sample every clock, with `fifo_rd` high continuously while data is available.
- **`underrun_clr` and a new underrun in the same cycle:** set wins.
- **`underrun_clr` while `underrun` is low:** no effect.
- **Entering IDLE:**
  - `sample_out`<=IDLE_SAMPLE on the next edge.
  - No strobe and no pop.
  - A partial period is discarded.
- **`fifo_rd` gating:** never asserted outside RUN and never while `fifo_empty`.

## Timing
- **Reset values (async assert):**
  - `fifo_rd`=0, `sample_stb`=0, `sample_out`=8'h80.
  - `underrun`=0, `underrun_cnt`=0, `busy`=0.
  - State IDLE, counter 0.
- **Startup:** `enable` rises with the FIFO already at or above PREFILL → PREFILL at edge 1, RUN at edge 2, `fifo_rd` high in the RUN cycle, `sample_stb` high one cycle after that.
- **Latency:** `fifo_rd` to `sample_stb`/`sample_out` is one clock.
- **Strobe spacing in RUN:** exactly `rate_div+1` clocks.
- **`enable` drop:** `busy` falls one clock after `enable` falls. A pop in that same cycle is suppressed.
- **Reset mid-RUN:** all outputs return to reset values immediately. The FIFO contents are not touched.

## Structure
- **Package `tx_pkg`:**
  - State enum `tx_state_t` (IDLE, PREFILL, RUN).
  - `TX_IDLE_SAMPLE` constant.
  - Default widths `TX_LEVEL_W`/`TX_RATE_W`.
- **Sub-module `tx_rate_tick`:** loadable down-counter. Inputs are `clr`, `run`, `period`; output is a one-cycle `tick`. It is reused by the modulator's symbol timing.
- **Top module:** FSM, output registers and underrun bookkeeping.

## Test plan
- Preload 64 bytes 0x00..0x3F, `rate_div`=3, raise `enable` → 64 strobes spaced 4 clocks carrying 0x00..0x3F in order, then one strobe with 0x80, `underrun`=1, `underrun_cnt`=1, state PREFILL.
- Preload 100 bytes, `rate_div`=0 → `fifo_rd` high for 100 consecutive clocks and 100 back-to-back strobes.
- FIFO at 63 with `enable` high → held in PREFILL with no `fifo_rd`. Write one byte → RUN within 2 clocks.
- Drop `enable` mid-period during RUN → no further strobes, `sample_out`=0x80 next clock, `busy`=0 next clock, FIFO level unchanged.
- Force 300 underruns (`PREFILL`=0, FIFO empty) → `underrun_cnt` holds 255. Pulse `underrun_clr` on an underrun tick → `underrun` stays 1.
- Assert `rst` low mid-RUN → every output at its reset value before the next clock edge.
